gcd_arbiter: RTL

GCD_ARBITER -- requirements
Module: gcd_arbiter

---
 rtl/gcd_arb_pkg.sv | 16 +
 rtl/gcd_arbiter_rr.sv | 34 +++
 rtl/gcd_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared definitions for the gcd_arbiter slice: controller state encoding and
// default parameter values.
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/gcd_arbiter_rr.sv
// Round-robin picker: scans from last_grant+1 upward, wrapping at NUM_REQ,
// and reports the first active requester as one-hot, index and any flag.
module gcd_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int   cand;
  logic hit;

  // first requester at or after last_grant+1 in rotating order wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    hit       = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand                 = (int'(last_grant) + i) % NUM_REQ;
      hit                  = !any_grant && req[IDX_W'(cand)];
      grant[IDX_W'(cand)]  = grant[IDX_W'(cand)] | hit;
      grant_idx            = hit ? IDX_W'(cand) : grant_idx;
      any_grant            = any_grant | hit;
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one external gcd core among NUM_REQ requesters: round-robin accept,
// zero-operand bypass, core timeout and held response per owner.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_result_o,
  output logic                        rsp_error_o,
  output logic                        core_start_o,
  output logic [DATA_W-1:0]           core_a_o,
  output logic [DATA_W-1:0]           core_b_o,
  input  logic                        core_done_i,
  input  logic [DATA_W-1:0]           core_result_i,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   next_grant;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_any;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic               accept;
  logic               zero_op;
  logic               timeout;
  logic               rsp_hs;

  gcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant),
    .grant      (win_onehot),
    .grant_idx  (win_idx),
    .any_grant  (win_any)
  );

  assign sel_a      = req_a_i[int'(win_idx)*DATA_W +: DATA_W];
  assign sel_b      = req_b_i[int'(win_idx)*DATA_W +: DATA_W];
  // gated by reset so the combinational strobe is also 0 while reset is held
  assign accept     = (state == S_IDLE) && win_any && !reset_i;
  assign zero_op    = (sel_a == '0) || (sel_b == '0);
  assign timeout    = (tmo_cnt == CNT_W'(TIMEOUT_CYC));
  assign rsp_hs     = rsp_ready_i[grant_id_o];
  assign next_grant = accept ? win_idx : grant_id_o;
  assign req_ready_o = accept ? win_onehot : '0;

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode; done takes priority over timeout in S_WAIT
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = zero_op ? S_RESP : S_ISSUE;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (core_done_i || timeout) begin
          next_state = S_RESP;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_RESP;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant   <= IDX_W'(NUM_REQ - 1);
      tmo_cnt      <= '0;
      grant_id_o   <= '0;
      core_a_o     <= '0;
      core_b_o     <= '0;
      core_start_o <= 1'b0;
      rsp_valid_o  <= '0;
      rsp_result_o <= '0;
      rsp_error_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      core_start_o <= accept && !zero_op;
      busy_o       <= (next_state != S_IDLE);
      rsp_valid_o  <= '0;
      if (next_state == S_RESP) begin
        rsp_valid_o[next_grant] <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            grant_id_o <= win_idx;
            core_a_o   <= sel_a;
            core_b_o   <= sel_b;
            if (zero_op) begin
              rsp_result_o <= sel_a | sel_b;
              rsp_error_o  <= 1'b0;
            end
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          if (core_done_i) begin
            rsp_result_o <= core_result_i;
            rsp_error_o  <= 1'b0;
          end else if (timeout) begin
            rsp_result_o <= '0;
            rsp_error_o  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_hs) begin
            last_grant <= grant_id_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
